// File: rtl/timer_pkg.sv
// Register map of the 32-bit memory-mapped timer and the poller FSM encoding,
// shared by the timer decode and the timer_poller sequencer.
package timer_pkg;

    localparam logic [1:0] ADDR_PERIOD  = 2'b00;
    localparam logic [1:0] ADDR_CONTROL = 2'b01;
    localparam logic [1:0] ADDR_STATUS  = 2'b10;

    // STATUS bit that reports a timeout; writing 1 to it clears the flag.
    localparam int unsigned STATUS_FLAG_BIT = 0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_PERIOD,
        ST_WR_EN,
        ST_RD_STAT,
        ST_WAIT_DATA,
        ST_WR_CLR,
        ST_WR_DIS,
        ST_DONE,
        ST_ABORT
    } poller_state_t;

endpackage

// File: rtl/timer_poller_if.sv
// Register bus between timer_poller (master) and the timer peripheral (slave).
interface timer_poller_if;

    logic [31:0] t_din;
    logic [31:0] t_dout;
    logic        t_wren;
    logic        t_rden;
    logic [1:0]  t_addr;

    modport master (
        output t_din, t_wren, t_rden, t_addr,
        input  t_dout
    );

    modport slave (
        input  t_din, t_wren, t_rden, t_addr,
        output t_dout
    );

endinterface

// File: rtl/timer_poller.sv
// Sequencer that programs the timer, counts N expirations by polling STATUS and
// reports done. Define TIMER_POLLER_TIMEOUT_EN to add the poll watchdog / abort.
module timer_poller
    import timer_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int ENBIT         = 0,
    parameter int TIMEOUT_POLLS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       period_val,
    input  logic [CNT_W-1:0]  target_count,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  event_count,
    timer_poller_if.master    tbus
);

    localparam logic [31:0] EN_MASK = 32'h1 << ENBIT;

    poller_state_t    state_q, state_d;
    logic [31:0]      period_q, period_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_inc;
    logic             flag_seen;

    assign count_inc   = count_q + 1'b1;
    assign flag_seen   = tbus.t_dout[STATUS_FLAG_BIT];
    assign event_count = count_q;

    // Only the flag bit of the read data matters to the sequencer.
    logic unused_dout;
    assign unused_dout = ^tbus.t_dout;

`ifdef TIMER_POLLER_TIMEOUT_EN
    localparam int POLL_W = $clog2(TIMEOUT_POLLS + 1);

    logic [POLL_W-1:0] poll_q, poll_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            poll_q <= '0;
        end else begin
            poll_q <= poll_d;
        end
    end

    always_comb begin
        poll_d = poll_q;
        if (state_q == ST_WR_PERIOD || state_q == ST_WR_CLR) begin
            poll_d = '0;
        end else if (state_q == ST_RD_STAT) begin
            poll_d = poll_q + 1'b1;
        end
    end

    assign error = (state_q == ST_ABORT);
`else
    // Without the watchdog there is no abort path, so error can never fire.
    assign error = (TIMEOUT_POLLS < 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            period_q <= '0;
            target_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            target_q <= target_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        target_d = target_q;
        count_d  = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_d = '0;
                    if (target_count != '0) begin
                        period_d = period_val;
                        target_d = target_count;
                        state_d  = ST_WR_PERIOD;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_WR_PERIOD: state_d = ST_WR_EN;
            ST_WR_EN:     state_d = ST_RD_STAT;
            ST_RD_STAT:   state_d = ST_WAIT_DATA;
            ST_WAIT_DATA: begin
                if (flag_seen) begin
                    state_d = ST_WR_CLR;
`ifdef TIMER_POLLER_TIMEOUT_EN
                end else if (poll_q == POLL_W'(TIMEOUT_POLLS)) begin
                    state_d = ST_ABORT;
`endif
                end else begin
                    state_d = ST_RD_STAT;
                end
            end
            ST_WR_CLR: begin
                count_d = count_inc;
                state_d = (count_inc == target_q) ? ST_WR_DIS : ST_RD_STAT;
            end
            ST_WR_DIS: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            ST_ABORT:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Bus and status outputs decode from the state register alone.
    always_comb begin
        tbus.t_addr = ADDR_PERIOD;
        tbus.t_din  = '0;
        tbus.t_wren = 1'b0;
        tbus.t_rden = 1'b0;
        busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done        = (state_q == ST_DONE);
        case (state_q)
            ST_WR_PERIOD: begin
                tbus.t_addr = ADDR_PERIOD;
                tbus.t_din  = period_q;
                tbus.t_wren = 1'b1;
            end
            ST_WR_EN: begin
                tbus.t_addr = ADDR_CONTROL;
                tbus.t_din  = EN_MASK;
                tbus.t_wren = 1'b1;
            end
            ST_RD_STAT: begin
                tbus.t_addr = ADDR_STATUS;
                tbus.t_rden = 1'b1;
            end
            ST_WR_CLR: begin
                tbus.t_addr = ADDR_STATUS;
                tbus.t_din  = 32'h1;
                tbus.t_wren = 1'b1;
            end
            ST_WR_DIS, ST_ABORT: begin
                tbus.t_addr = ADDR_CONTROL;
                tbus.t_din  = 32'h0;
                tbus.t_wren = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_timer_poller.sv
// Directed bench for timer_poller with a behavioural timer on the bus; the
// watchdog scenario runs only when TIMER_POLLER_TIMEOUT_EN is defined.
module tb_timer_poller;
    import timer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] period_val = '0;
    logic [15:0] target_count = '0;
    logic        busy, done, error;
    logic [15:0] event_count;

    timer_poller_if bus ();

    timer_poller #(
        .CNT_W         (16),
        .ENBIT         (0),
        .TIMEOUT_POLLS (4)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .start        (start),
        .period_val   (period_val),
        .target_count (target_count),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .event_count  (event_count),
        .tbus         (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural timer: counts 0..period while enabled, flags on wrap.
    logic [31:0] tm_period, tm_cnt;
    logic        tm_en, tm_flag;
    logic        preset_flag = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tm_period  <= '0;
            tm_cnt     <= '0;
            tm_en      <= 1'b0;
            tm_flag    <= 1'b0;
            bus.t_dout <= '0;
        end else begin
            if (tm_en) begin
                if (tm_cnt == tm_period) begin
                    tm_cnt  <= '0;
                    tm_flag <= 1'b1;
                end else begin
                    tm_cnt <= tm_cnt + 1;
                end
            end
            if (preset_flag) tm_flag <= 1'b1;
            if (bus.t_wren) begin
                case (bus.t_addr)
                    ADDR_PERIOD:  tm_period <= bus.t_din;
                    ADDR_CONTROL: begin tm_en <= bus.t_din[0]; tm_cnt <= '0; end
                    ADDR_STATUS:  if (bus.t_din[STATUS_FLAG_BIT]) tm_flag <= 1'b0;
                    default: ;
                endcase
            end
            if (bus.t_rden) begin
                if (bus.t_addr == ADDR_STATUS)       bus.t_dout <= {31'b0, tm_flag};
                else if (bus.t_addr == ADDR_PERIOD)  bus.t_dout <= tm_period;
                else                                 bus.t_dout <= {31'b0, tm_en};
            end
        end
    end

    // Bus monitor, sampled mid-cycle.
    logic [1:0]  wr_addr [64];
    logic [31:0] wr_data [64];
    int          wr_cyc  [64];
    int          rd_cyc  [512];
    int wr_n = 0, rd_n = 0, both_n = 0, done_n = 0, done_cyc = 0, busy_n = 0, err_n = 0;

    always @(negedge clk) begin
        if (bus.t_wren) begin
            if (wr_n < 64) begin
                wr_addr[wr_n] = bus.t_addr;
                wr_data[wr_n] = bus.t_din;
                wr_cyc[wr_n]  = cyc;
            end
            wr_n++;
        end
        if (bus.t_rden) begin
            if (rd_n < 512) rd_cyc[rd_n] = cyc;
            rd_n++;
        end
        if (bus.t_wren && bus.t_rden) both_n++;
        if (done) begin done_n++; done_cyc = cyc; end
        if (busy) busy_n++;
        if (error) err_n++;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic pulse_start(input logic [31:0] p, input logic [15:0] t, output int sc);
        @(negedge clk);
        start = 1'b1; period_val = p; target_count = t; sc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int d0, input int e0, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk); #1;
            if (done_n > d0 || err_n > e0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({busy, done, error, bus.t_wren, bus.t_rden} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000", {busy, done, error, bus.t_wren, bus.t_rden});
        else n_pass++;
        n_checks++;
        if ({bus.t_addr, bus.t_din} !== 34'h0)
            $display("FAIL reset_bus: got addr=%h din=%h expected 0/0", bus.t_addr, bus.t_din);
        else n_pass++;
        n_checks++;
        if (event_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", event_count);
        else n_pass++;
        rst_n = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_basic();
        int sc, w0, r0, d0, st; bit ok;
        w0 = wr_n; r0 = rd_n; d0 = done_n;
        pulse_start(32'h0F, 16'd3, sc);
        wait_end(d0, err_n, 400, ok);
        n_checks++;
        if (!ok) $display("FAIL basic_timeout: done not seen within 400 cycles"); else n_pass++;
        repeat (3) @(negedge clk); #1;
        n_checks++;
        if (wr_n - w0 !== 6) $display("FAIL basic_wr_count: got %0d expected 6", wr_n - w0); else n_pass++;
        n_checks++;
        if ({wr_addr[w0], wr_data[w0]} !== {2'b00, 32'h0F})
            $display("FAIL basic_period: got %h/%h expected 0/0000000f", wr_addr[w0], wr_data[w0]);
        else n_pass++;
        n_checks++;
        if ({wr_addr[w0+1], wr_data[w0+1]} !== {2'b01, 32'h1})
            $display("FAIL basic_enable: got %h/%h expected 1/00000001", wr_addr[w0+1], wr_data[w0+1]);
        else n_pass++;
        st = 0;
        for (int i = 2; i < 5; i++) if ({wr_addr[w0+i], wr_data[w0+i]} === {2'b10, 32'h1}) st++;
        n_checks++;
        if (st !== 3) $display("FAIL basic_clears: got %0d expected 3", st); else n_pass++;
        n_checks++;
        if ({wr_addr[w0+5], wr_data[w0+5]} !== {2'b01, 32'h0})
            $display("FAIL basic_disable: got %h/%h expected 1/00000000", wr_addr[w0+5], wr_data[w0+5]);
        else n_pass++;
        n_checks++;
        if (wr_cyc[w0] !== sc + 1) $display("FAIL basic_first_wr: got cycle %0d expected %0d", wr_cyc[w0], sc + 1);
        else n_pass++;
        n_checks++;
        if (rd_cyc[r0] !== sc + 3) $display("FAIL basic_first_rd: got cycle %0d expected %0d", rd_cyc[r0], sc + 3);
        else n_pass++;
        n_checks++;
        if (rd_cyc[r0+1] - rd_cyc[r0] !== 2)
            $display("FAIL basic_poll_gap: got %0d expected 2", rd_cyc[r0+1] - rd_cyc[r0]);
        else n_pass++;
        n_checks++;
        if (done_cyc !== wr_cyc[w0+4] + 2)
            $display("FAIL basic_done_lat: got cycle %0d expected %0d", done_cyc, wr_cyc[w0+4] + 2);
        else n_pass++;
        n_checks++;
        if (done_n - d0 !== 1) $display("FAIL basic_done_once: got %0d expected 1", done_n - d0); else n_pass++;
        n_checks++;
        if (event_count !== 16'd3) $display("FAIL basic_count: got %0d expected 3", event_count); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL basic_busy_idle: got %b expected 0", busy); else n_pass++;
        $display("basic: target=3 writes=%0d count=%0d", wr_n - w0, event_count);
    endtask

    task automatic test_zero_target();
        int sc, w0, r0, d0, b0; bit ok;
        w0 = wr_n; r0 = rd_n; d0 = done_n; b0 = busy_n;
        pulse_start(32'h55, 16'd0, sc);
        wait_end(d0, err_n, 20, ok);
        repeat (3) @(negedge clk); #1;
        n_checks++;
        if (!ok || done_cyc !== sc + 1)
            $display("FAIL zero_done_cycle: got cycle %0d expected %0d", done_cyc, sc + 1);
        else n_pass++;
        n_checks++;
        if ((wr_n - w0) + (rd_n - r0) !== 0)
            $display("FAIL zero_no_bus: got %0d strobes expected 0", (wr_n - w0) + (rd_n - r0));
        else n_pass++;
        n_checks++;
        if (busy_n - b0 !== 0) $display("FAIL zero_busy: got %0d busy cycles expected 0", busy_n - b0); else n_pass++;
        $display("zero_target: done at +%0d", done_cyc - sc);
    endtask

    task automatic test_back_to_back();
        int sc, sc2, w0, d0, st; bit ok;
        w0 = wr_n; d0 = done_n;
        pulse_start(32'h0F, 16'd2, sc);
        repeat (4) @(negedge clk);
        pulse_start(32'h03, 16'd7, sc2);
        wait_end(d0, err_n, 400, ok);
        n_checks++;
        if (!ok) $display("FAIL b2b_timeout: done not seen within 400 cycles"); else n_pass++;
        repeat (20) @(negedge clk); #1;
        n_checks++;
        if (wr_n - w0 !== 5) $display("FAIL b2b_wr_count: got %0d expected 5", wr_n - w0); else n_pass++;
        n_checks++;
        if ({wr_addr[w0], wr_data[w0]} !== {2'b00, 32'h0F})
            $display("FAIL b2b_period: got %h/%h expected 0/0000000f", wr_addr[w0], wr_data[w0]);
        else n_pass++;
        st = 0;
        for (int i = 0; i < 5; i++) if (wr_addr[w0+i] === ADDR_STATUS) st++;
        n_checks++;
        if (st !== 2) $display("FAIL b2b_clears: got %0d expected 2", st); else n_pass++;
        n_checks++;
        if (event_count !== 16'd2) $display("FAIL b2b_count: got %0d expected 2", event_count); else n_pass++;
        n_checks++;
        if (done_n - d0 !== 1) $display("FAIL b2b_done_once: got %0d expected 1", done_n - d0); else n_pass++;
        $display("back_to_back: second start at +%0d ignored, count=%0d", sc2 - sc, event_count);
    endtask

    task automatic test_flag_first();
        int sc, w0, r0, d0; bit ok;
        w0 = wr_n; r0 = rd_n; d0 = done_n;
        @(negedge clk); preset_flag = 1'b1;
        @(negedge clk); preset_flag = 1'b0;
        pulse_start(32'hFFFF_FFFF, 16'd1, sc);
        wait_end(d0, err_n, 50, ok);
        n_checks++;
        if (!ok) $display("FAIL flag_first_timeout: done not seen within 50 cycles"); else n_pass++;
        repeat (2) @(negedge clk); #1;
        n_checks++;
        if (rd_n - r0 !== 1) $display("FAIL flag_first_reads: got %0d expected 1", rd_n - r0); else n_pass++;
        n_checks++;
        if (wr_addr[w0+2] !== ADDR_STATUS || wr_cyc[w0+2] !== rd_cyc[r0] + 2)
            $display("FAIL flag_first_clr_lat: got addr %h cycle %0d expected 2/%0d",
                     wr_addr[w0+2], wr_cyc[w0+2], rd_cyc[r0] + 2);
        else n_pass++;
        n_checks++;
        if (event_count !== 16'd1) $display("FAIL flag_first_count: got %0d expected 1", event_count); else n_pass++;
        $display("flag_first: read at %0d clear at %0d", rd_cyc[r0], wr_cyc[w0+2]);
    endtask

    task automatic test_reset_mid_run();
        int sc; bit ok;
        pulse_start(32'h0F, 16'd5, sc);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (event_count == 16'd2 && bus.t_rden) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) $display("FAIL rstmid_reach: poll read after 2 events not seen"); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.t_rden, busy} !== 2'b00) $display("FAIL rstmid_async: got rden/busy=%b expected 00", {bus.t_rden, busy});
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if ({busy, bus.t_wren, bus.t_rden} !== 3'b000 || event_count !== 16'd0)
            $display("FAIL rstmid_idle: got flags=%b count=%0d expected 000/0", {busy, bus.t_wren, bus.t_rden}, event_count);
        else n_pass++;
        $display("reset_mid_run: idle after release, count=%0d", event_count);
    endtask

`ifdef TIMER_POLLER_TIMEOUT_EN
    task automatic test_timeout();
        int sc, w0, r0, d0, e0; bit ok;
        w0 = wr_n; r0 = rd_n; d0 = done_n; e0 = err_n;
        pulse_start(32'hFFFF_FFFF, 16'd2, sc);
        wait_end(d0, e0, 100, ok);
        n_checks++;
        if (!ok) $display("FAIL timeout_timeout: error not seen within 100 cycles"); else n_pass++;
        repeat (3) @(negedge clk); #1;
        n_checks++;
        if (rd_n - r0 !== 4) $display("FAIL timeout_reads: got %0d expected 4", rd_n - r0); else n_pass++;
        n_checks++;
        if (wr_n - w0 !== 3 || {wr_addr[w0+2], wr_data[w0+2]} !== {2'b01, 32'h0})
            $display("FAIL timeout_disable: got %0d writes last %h/%h expected 3 1/00000000",
                     wr_n - w0, wr_addr[w0+2], wr_data[w0+2]);
        else n_pass++;
        n_checks++;
        if (err_n - e0 !== 1 || done_n !== d0)
            $display("FAIL timeout_pulses: got error=%0d done=%0d expected 1/0", err_n - e0, done_n - d0);
        else n_pass++;
        n_checks++;
        if (event_count !== 16'd0) $display("FAIL timeout_count: got %0d expected 0", event_count); else n_pass++;
        $display("timeout: aborted after %0d reads", rd_n - r0);
    endtask
`else
    task automatic test_no_error();
        n_checks++;
        if (err_n !== 0 || error !== 1'b0) $display("FAIL no_error: got %0d error cycles expected 0", err_n);
        else n_pass++;
        $display("no_error: error stayed low");
    endtask
`endif

    task automatic test_bus_exclusive();
        n_checks++;
        if (both_n !== 0) $display("FAIL bus_exclusive: got %0d overlapping cycles expected 0", both_n);
        else n_pass++;
        $display("bus_exclusive: overlaps=%0d", both_n);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_target();
        test_back_to_back();
        test_flag_first();
        test_reset_mid_run();
`ifdef TIMER_POLLER_TIMEOUT_EN
        test_timeout();
`else
        test_no_error();
`endif
        test_bus_exclusive();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/timer_poller.md
# timer_poller

Bus-master sequencer that sits directly on the register interface of the 32-bit memory-mapped timer peripheral and is its only driver. On a start pulse it programs the timer period, enables the timer, then polls the status register, clearing the timeout flag and counting each expiration. When the requested number of expirations has been seen it disables the timer and reports done. It turns the timer into a self-contained "wait N periods" service for the rest of the lab design.

## Interface
- `CNT_W`, 16: width of the expiration target and counter.
- `ENBIT`, 0: bit index of the enable bit in the timer control register.
- `TIMEOUT_POLLS`, 1024: status reads allowed without a flag before abort. Used only with the watchdog macro.
- `clk` in 1: single clock; everything is on its rising edge.
- `reset` in 1: asynchronous, active-low; asserting it forces all state and outputs to their reset values at once.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `period_val` in 32: timer period; captured on an accepted start.
- `target_count` in CNT_W: number of expirations to wait; captured on an accepted start.
- `busy` out 1: high from the cycle after start is accepted until the return to IDLE.
- `done` out 1: one-cycle pulse on completion.
- `error` out 1: one-cycle pulse on watchdog abort. Tied 0 without the macro.
- `event_count` out CNT_W: expirations seen in the current or last run.
- `t_din` out 32: write data to the timer.
- `t_dout` in 32: read data from the timer.
- `t_wren` out 1: timer write strobe.
- `t_rden` out 1: timer read strobe.
- `t_addr` out 2: timer register select.

## Operation
- Timer register map: 2'b00 PERIOD; 2'b01 CONTROL (bit ENBIT = enable); 2'b10 STATUS (bit 0 = timeout flag; writing 1 to bit 0 clears it).
- Bus rules:
  - At most one of t_wren and t_rden is high in any cycle.
  - A write takes effect at the clock edge where t_wren is high.
  - Read data on t_dout is valid the cycle after t_rden is high.
  - The strobes are single-cycle.
- FSM states and transitions:
  - IDLE: on start with target_count≠0, capture the inputs, clear event_count, go to WR_PERIOD. On start with target_count=0, go to DONE with no bus traffic. Otherwise stay.
  - WR_PERIOD: t_addr=00, t_din=period, t_wren=1. Next state WR_EN.
  - WR_EN: t_addr=01, t_din=1<<ENBIT, t_wren=1. Next state RD_STAT.
  - RD_STAT: t_addr=10, t_rden=1. Next state WAIT_DATA.
  - WAIT_DATA: sample t_dout[0]. If 1, go to WR_CLR. If 0, go to RD_STAT.
  - WR_CLR: t_addr=10, t_din=32'h1, t_wren=1, event_count+1. If the new count equals target, go to WR_DIS; otherwise go to RD_STAT.
  - WR_DIS: t_addr=01, t_din=0, t_wren=1. Next state DONE.
  - DONE: done=1. Next state IDLE.
- event_count holds its value in IDLE until the next accepted start.
- start outside IDLE is ignored.
- Counter arithmetic is unsigned CNT_W. The counter cannot wrap because a run ends at target_count ≤ 2^CNT_W−1.

## Timing
- Reset values: state IDLE; busy, done, error, t_wren, t_rden all 0; t_addr 0; t_din 0; event_count 0.
- All outputs are registered or decoded from state only; none depends combinationally on t_dout or start.
- Start to first timer write: 1 cycle. Start to first status read: 3 cycles.
- Poll loop: 2 cycles per status read.
- Detected flag to clear write: 1 cycle.
- Last clear to done pulse: 2 cycles (WR_DIS, then DONE).
- Reset mid-run: strobes drop in the same cycle reset asserts. The timer is not explicitly disabled; it must itself be on the same reset.

## Configuration
- `TIMER_POLLER_TIMEOUT_EN` defined: a poll counter clears on entry to WR_EN and on each WR_CLR, and increments on each RD_STAT. When it reaches TIMEOUT_POLLS with no flag, WAIT_DATA goes to an ABORT state: disable write to CONTROL, error=1 for one cycle, done stays 0, then IDLE. event_count keeps its partial value.
- Not defined: no poll counter, no ABORT state, error tied 0. Polling continues indefinitely.

## Structure
- Shared package `timer_pkg`:
  - Register address constants ADDR_PERIOD, ADDR_CONTROL, ADDR_STATUS.
  - STATUS flag bit index.
  - FSM state enum `poller_state_t`.
- The timer module uses the same package for its decode.
- No sub-module; a single FSM plus counters.

## Test plan
- period_val=32'h0F, target_count=3, timer model flags every 16 cycles:
  - writes PERIOD=0x0F, then CONTROL=0x1;
  - exactly 3 writes of STATUS=0x1;
  - then CONTROL=0x0; done pulses once; event_count=3.
- target_count=0: done pulses in the cycle after start; t_wren and t_rden never assert; busy never asserts.
- start pulsed again while busy: ignored, no re-capture of inputs, run completes as for a single start.
- reset asserted during the poll loop: t_rden and busy go 0 asynchronously; after release the block is in IDLE with event_count=0.
- Flag already set at the first read: clear write occurs 2 cycles after that read; event_count increments once.
- With macro defined, TIMEOUT_POLLS=4, timer never flags: after 4 reads a CONTROL=0 write occurs, error pulses, done=0, event_count=0.
